// File: rtl/run_controller.sv
// Execution sequencer: turns operator buttons and the datapath HALT flag into
// registered step_en/load_en strobes. Optional breakpoint: RUN_CONTROLLER_BREAKPOINT_EN.
module run_controller #(
  parameter int unsigned RUN_DIV = 4,
  parameter int unsigned STEPS_W = 16
`ifdef RUN_CONTROLLER_BREAKPOINT_EN
  ,
  parameter int unsigned BP_W    = 8
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               NEXT,
  input  logic               RUN,
  input  logic               SPEEDRUN,
  input  logic               STOP,
  input  logic               LOAD,
  input  logic               HALT,
  output logic               step_en,
  output logic               load_en,
  output logic               busy,
  output logic [2:0]         state,
`ifdef RUN_CONTROLLER_BREAKPOINT_EN
  output logic [STEPS_W-1:0] steps,
  input  logic [BP_W-1:0]    pc,
  input  logic [BP_W-1:0]    bp_addr,
  input  logic               bp_valid
`else
  output logic [STEPS_W-1:0] steps
`endif
);

  localparam int unsigned NBTN  = 5;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned B_LOAD  = 0;
  localparam int unsigned B_NEXT  = 1;
  localparam int unsigned B_RUN   = 2;
  localparam int unsigned B_SPEED = 3;
  localparam int unsigned B_STOP  = 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STEP   = 3'd1,
    S_RUN    = 3'd2,
    S_SPEED  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t             r_state, w_nxt_state;
  logic [NBTN-1:0]    r_s1, r_s2, r_s3;
  logic [NBTN-1:0]    w_btn, w_press;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic               r_step_en, r_load_en, r_busy;
  logic               w_step_nxt, w_load_nxt, w_bp_hit;
  logic [STEPS_W-1:0] r_steps;

  assign w_btn   = {STOP, SPEEDRUN, RUN, NEXT, LOAD};
  assign w_press = r_s2 & ~r_s3;

`ifdef RUN_CONTROLLER_BREAKPOINT_EN
  // Compare against the PC the counter will hold next cycle (it advances by one per step_en).
  logic [BP_W-1:0] w_pc_nxt;
  assign w_pc_nxt = pc + BP_W'(r_step_en);
  assign w_bp_hit = bp_valid && (w_pc_nxt == bp_addr);
`else
  assign w_bp_hit = 1'b0;
`endif

  // Button synchronizers and edge-history flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Next-state and next-strobe decode
  always_comb begin
    w_nxt_state = r_state;
    w_step_nxt  = 1'b0;
    w_load_nxt  = 1'b0;
    w_div_nxt   = r_div;
    case (r_state)
      S_IDLE: begin
        if (HALT) begin
          w_nxt_state = S_HALTED;
        end else if (w_press[B_LOAD]) begin
          w_load_nxt = 1'b1;
        end else if (w_press[B_NEXT]) begin
          w_nxt_state = S_STEP;
          w_step_nxt  = 1'b1;
        end else if (w_press[B_RUN]) begin
          w_nxt_state = S_RUN;
          w_div_nxt   = '0;
        end else if (w_press[B_SPEED] && !w_bp_hit) begin
          w_nxt_state = S_SPEED;
          w_step_nxt  = 1'b1;
        end
      end
      S_STEP: begin
        w_nxt_state = HALT ? S_HALTED : S_IDLE;
      end
      S_RUN: begin
        if (HALT) begin
          w_nxt_state = S_HALTED;
        end else if (w_press[B_STOP] || w_press[B_NEXT] || w_bp_hit) begin
          w_nxt_state = S_IDLE;
        end else begin
          w_div_nxt  = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
          w_step_nxt = (w_div_nxt == DIV_LAST);
        end
      end
      S_SPEED: begin
        if (HALT) begin
          w_nxt_state = S_HALTED;
        end else if (w_press[B_STOP] || w_press[B_NEXT] || w_bp_hit) begin
          w_nxt_state = S_IDLE;
        end else begin
          w_step_nxt = 1'b1;
        end
      end
      S_HALTED: begin
        if (w_press[B_LOAD]) begin
          w_nxt_state = S_IDLE;
          w_load_nxt  = 1'b1;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // State, divider and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_step_en <= 1'b0;
      r_load_en <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_div     <= w_div_nxt;
      r_step_en <= w_step_nxt;
      r_load_en <= w_load_nxt;
      r_busy    <= (w_nxt_state == S_RUN) || (w_nxt_state == S_SPEED);
    end
  end

  // Executed-step count: cleared by a load, saturating otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_steps <= '0;
    end else if (r_load_en) begin
      r_steps <= '0;
    end else if (r_step_en && (r_steps != '1)) begin
      r_steps <= r_steps + STEPS_W'(1);
    end
  end

  assign step_en = r_step_en;
  assign load_en = r_load_en;
  assign busy    = r_busy;
  assign state   = r_state;
  assign steps   = r_steps;

endmodule
